fb_row_reader: RTL

Read-side sequencer for the lane-split framebuffer memory. On each row request it walks every column of that row through the memory's read port and absorbs the one-cycle read latency. It returns one full-width word per column (all subpanels, all colour bytes) to the HUB75 shift stage over a valid/ready handshake. It sits between the row/brightness scheduler and the pixel shifter, in the clk_root domain.

---
 rtl/fb_row_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fb_row_reader.sv
// Row read sequencer: walks one framebuffer row through a 1-cycle-latency read port and streams column words out.
// Optional build macro FB_ROW_READER_MIRROR_EN reverses the column order for horizontally flipped panels.
module fb_row_reader #(
    parameter int PIXEL_WIDTH      = 64,
    parameter int PIXEL_HALFHEIGHT = 16,
    parameter int SUBPANELS        = 2,
    parameter int BYTES_PER_PIXEL  = 2,
    parameter int DW               = 8,
    localparam int LANES = SUBPANELS * BYTES_PER_PIXEL,
    localparam int COLB  = $clog2(PIXEL_WIDTH),
    localparam int ROWB  = $clog2(PIXEL_HALFHEIGHT),
    localparam int AB    = ROWB + COLB
) (
    input  logic                  clk_root,
    input  logic                  reset_n,
    input  logic                  row_req,
    input  logic [ROWB-1:0]       row_addr,
    output logic                  row_ack,
    output logic                  row_done,
    output logic [AB-1:0]         mem_addr,
    output logic                  mem_en,
    input  logic [LANES*DW-1:0]   mem_q,
    output logic [LANES*DW-1:0]   pix_data,
    output logic [COLB-1:0]       pix_col,
    output logic                  pix_last,
    output logic                  pix_valid,
    input  logic                  pix_ready
);

`ifdef FB_ROW_READER_MIRROR_EN
    localparam logic [COLB-1:0] COL_FIRST = COLB'(PIXEL_WIDTH - 1);
    localparam logic [COLB-1:0] COL_LAST  = '0;
`else
    localparam logic [COLB-1:0] COL_FIRST = '0;
    localparam logic [COLB-1:0] COL_LAST  = COLB'(PIXEL_WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ROWB-1:0]     row_reg, row_next;
    logic [COLB-1:0]     col_reg, col_next;
    logic                issue, done;

    logic                inflight_reg;
    logic [COLB-1:0]     inflight_col_reg;
    logic                inflight_last_reg;

    logic [LANES*DW-1:0] fifo_data_reg [2];
    logic [COLB-1:0]     fifo_col_reg  [2];
    logic                fifo_last_reg [2];
    logic                wr_ptr_reg, rd_ptr_reg;
    logic [1:0]          count_reg;

    logic                head_valid, pop;
    logic [1:0]          occupancy;

    assign head_valid = (count_reg != 2'd0);
    assign pop        = head_valid && pix_ready;
    // A word leaving this cycle frees its slot for the read issued now, keeping one word per cycle.
    assign occupancy  = count_reg - {1'b0, pop} + {1'b0, inflight_reg};

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        issue      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (row_req) begin
                    row_next   = row_addr;
                    col_next   = COL_FIRST;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (occupancy < 2'd2) begin
                    issue = 1'b1;
                    if (col_reg == COL_LAST) begin
                        state_next = DRAIN;
                    end else begin
`ifdef FB_ROW_READER_MIRROR_EN
                        col_next = col_reg - 1'b1;
`else
                        col_next = col_reg + 1'b1;
`endif
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_last_reg[rd_ptr_reg]) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_root) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_root) begin
        if (!reset_n) begin
            row_reg           <= '0;
            col_reg           <= '0;
            inflight_reg      <= 1'b0;
            inflight_col_reg  <= '0;
            inflight_last_reg <= 1'b0;
        end else begin
            row_reg           <= row_next;
            col_reg           <= col_next;
            inflight_reg      <= issue;
            inflight_col_reg  <= col_reg;
            inflight_last_reg <= (col_reg == COL_LAST);
        end
    end

    always_ff @(posedge clk_root) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)          rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

    // Returning read data lands in whichever slot the write pointer selects.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge clk_root) begin
                if (!reset_n) begin
                    fifo_data_reg[gi] <= '0;
                    fifo_col_reg[gi]  <= '0;
                    fifo_last_reg[gi] <= 1'b0;
                end else if (inflight_reg && (int'(wr_ptr_reg) == gi)) begin
                    fifo_data_reg[gi] <= mem_q;
                    fifo_col_reg[gi]  <= inflight_col_reg;
                    fifo_last_reg[gi] <= inflight_last_reg;
                end
            end
        end
    endgenerate

    assign row_ack   = reset_n && (state_reg == IDLE);
    assign row_done  = reset_n && done;
    assign mem_en    = reset_n && issue;
    assign mem_addr  = mem_en ? {row_reg, col_reg} : '0;
    assign pix_valid = reset_n && head_valid;
    assign pix_data  = pix_valid ? fifo_data_reg[rd_ptr_reg] : '0;
    assign pix_col   = pix_valid ? fifo_col_reg[rd_ptr_reg]  : '0;
    assign pix_last  = pix_valid && fifo_last_reg[rd_ptr_reg];

endmodule
